saw_receiver: RTL

Receiving end of the Stop-and-Wait ARQ link. Accepts BW-bit frames from the channel, checks parity and sequence bit, delivers new payloads to the upper layer over a valid/ready handshake, and returns an ACK carrying the received sequence bit. Duplicate frames (retransmissions after a lost ACK) are re-ACKed but not delivered again. Corrupted frames are dropped silently, and the transmitter's timer recovers them.

---
 rtl/saw_receiver_if.sv | 41 ++++
 rtl/saw_receiver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/saw_receiver_if.sv
// -----------------------------------------------------------------------------
// saw_receiver_if
// Groups the Stop-and-Wait receiver's channel, delivery and ACK signals.
//
// Parameters:
//   BW        frame width (seq bit + BW-2 payload bits + parity bit)
// Signals:
//   rx_valid  channel frame valid            (channel -> receiver)
//   rx_frame  channel frame, BW bits         (channel -> receiver)
//   rx_ready  receiver can accept a frame    (receiver -> channel)
//   out_valid delivered payload valid        (receiver -> upper layer)
//   out_data  delivered payload, BW-2 bits   (receiver -> upper layer)
//   out_ready upper layer accepts payload    (upper layer -> receiver)
//   ack_valid one-cycle ACK pulse            (receiver -> channel)
//   ack_seq   sequence bit being ACKed       (receiver -> channel)
// Modports:
//   master    the environment (channel + upper layer)
//   slave     the receiver
// -----------------------------------------------------------------------------
interface saw_receiver_if #(
    parameter int BW = 10
);
    logic          rx_valid;
    logic [BW-1:0] rx_frame;
    logic          rx_ready;
    logic          out_valid;
    logic [BW-3:0] out_data;
    logic          out_ready;
    logic          ack_valid;
    logic          ack_seq;

    modport master (
        output rx_valid, rx_frame, out_ready,
        input  rx_ready, out_valid, out_data, ack_valid, ack_seq
    );

    modport slave (
        input  rx_valid, rx_frame, out_ready,
        output rx_ready, out_valid, out_data, ack_valid, ack_seq
    );
endinterface

// File: rtl/saw_receiver.sv
// -----------------------------------------------------------------------------
// saw_receiver
// Receiving end of a Stop-and-Wait ARQ link. Latches one frame at a time,
// checks even parity and the sequence bit, delivers new payloads over a
// valid/ready handshake and ACKs them. Duplicates are re-ACKed but not
// delivered; parity failures are dropped (or NAKed, see below).
//
// Frame layout: [BW-1] seq, [BW-2:1] payload, [0] even parity over [BW-1:1].
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   bus       saw_receiver_if.slave (rx_*, out_*, ack_*)
//   nak_valid one-cycle NAK pulse on parity failure (SAW_RX_NAK_EN only)
//   err_cnt   saturating count of parity-failed frames
//   dup_cnt   saturating count of duplicate frames
//
// Optional feature macro: SAW_RX_NAK_EN
//   defined   : parity failures produce a one-cycle NAK carrying exp_seq
//   undefined : parity failures are dropped silently
//
// Every output is decoded from registered state/data; there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module saw_receiver #(
    parameter int BW = 10,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    saw_receiver_if.slave bus,
`ifdef SAW_RX_NAK_EN
    output logic          nak_valid,
`endif
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] dup_cnt
);

`ifdef SAW_RX_NAK_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DELIVER,
        S_ACK,
        S_NAK
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_DELIVER,
        S_ACK
    } state_t;
`endif

    state_t        r_state;
    state_t        w_next;
    logic [BW-1:0] r_frame;
    logic          r_exp_seq;
    logic          r_ack_seq;
    logic [CW-1:0] r_err_cnt;
    logic [CW-1:0] r_dup_cnt;

    logic          w_accept;
    logic          w_err_inc;
    logic          w_dup_inc;
    logic          w_toggle;
    logic          w_ack_seq_d;
    logic          w_seq;
    logic          w_parity;

    assign w_seq    = r_frame[BW-1];
    // Even parity over the whole frame: a clean frame XORs to zero.
    assign w_parity = ^r_frame;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_err_inc   = 1'b0;
        w_dup_inc   = 1'b0;
        w_toggle    = 1'b0;
        w_ack_seq_d = r_ack_seq;
        case (r_state)
            S_IDLE: begin
                // rx_ready is 1 exactly in IDLE, so rx_valid alone qualifies.
                if (bus.rx_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_parity) begin
                    w_err_inc = 1'b1;
`ifdef SAW_RX_NAK_EN
                    w_ack_seq_d = r_exp_seq;
                    w_next      = S_NAK;
`else
                    w_next      = S_IDLE;
`endif
                end else if (w_seq == r_exp_seq) begin
                    w_next = S_DELIVER;
                end else begin
                    // Retransmission after a lost ACK: re-ACK, do not deliver.
                    w_dup_inc   = 1'b1;
                    w_ack_seq_d = w_seq;
                    w_next      = S_ACK;
                end
            end
            S_DELIVER: begin
                if (bus.out_ready) begin
                    w_toggle    = 1'b1;
                    w_ack_seq_d = w_seq;
                    w_next      = S_ACK;
                end
            end
            S_ACK: begin
                w_next = S_IDLE;
            end
`ifdef SAW_RX_NAK_EN
            S_NAK: begin
                w_next = S_IDLE;
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame   <= '0;
            r_exp_seq <= 1'b0;
            r_ack_seq <= 1'b0;
            r_err_cnt <= '0;
            r_dup_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_frame <= bus.rx_frame;
            end
            if (w_toggle) begin
                r_exp_seq <= ~r_exp_seq;
            end
            // ack_seq only changes on entry to ACK/NAK and holds otherwise.
            r_ack_seq <= w_ack_seq_d;
            if (w_err_inc && (r_err_cnt != {CW{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_dup_inc && (r_dup_cnt != {CW{1'b1}})) begin
                r_dup_cnt <= r_dup_cnt + 1'b1;
            end
        end
    end

    assign bus.rx_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DELIVER);
    assign bus.out_data  = r_frame[BW-2:1];
    assign bus.ack_valid = (r_state == S_ACK);
    assign bus.ack_seq   = r_ack_seq;
`ifdef SAW_RX_NAK_EN
    assign nak_valid     = (r_state == S_NAK);
`endif
    assign err_cnt       = r_err_cnt;
    assign dup_cnt       = r_dup_cnt;

endmodule
